// File: rtl/input_conditioner_if.sv
// Field-input bundle between the plant contacts and the input conditioner.
// Edge pulse signals exist only when INPUT_EDGE_EN is defined.
interface input_conditioner_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] cond_out;
  logic             changed;

`ifdef INPUT_EDGE_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (
    input  raw_in,
    output cond_out,
    output changed,
    output rise,
    output fall
  );

  modport slave (
    output raw_in,
    input  cond_out,
    input  changed,
    input  rise,
    input  fall
  );
`else
  modport master (
    input  raw_in,
    output cond_out,
    output changed
  );

  modport slave (
    output raw_in,
    input  cond_out,
    input  changed
  );
`endif

endinterface

// File: rtl/input_conditioner.sv
// Two-flop synchronizer plus per-bit debounce counter for digital plant inputs.
// Optional per-bit rise/fall pulses are built when INPUT_EDGE_EN is defined.
module input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input_conditioner_if.master  bus
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } bit_state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] upd;
  logic             changed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.raw_in;
      s2 <= s1;
    end
  end

  // Each contact owns its own state and counter; a bit commits only after
  // s2 has disagreed with the output for DEBOUNCE_CYCLES consecutive edges.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bit_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cond_q;
    logic             differs;

    assign differs = (s2[i] != cond_q);
    assign upd[i]  = differs && (cnt_q == CNT_LAST);
    assign cond[i] = cond_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        cond_q  <= 1'b0;
      end else if (differs) begin
        if (cnt_q == CNT_LAST) begin
          cond_q  <= s2[i];
          cnt_q   <= '0;
          state_q <= STABLE;
        end else begin
          cnt_q   <= (state_q == STABLE) ? CNT_ONE : cnt_q + CNT_ONE;
          state_q <= PENDING;
        end
      end else begin
        cnt_q   <= '0;
        state_q <= STABLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |upd;
    end
  end

  assign bus.cond_out = cond;
  assign bus.changed  = changed_q;

`ifdef INPUT_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // The committed value is s2 itself, so its level tells the edge direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & s2;
      fall_q <= upd & ~s2;
    end
  end

  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`endif

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter WIDTH, default 8, number of digital plant inputs conditioned; the processor top sets it to inputNumber.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before an output changes; legal range 1..65535.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 raw_in  input  WIDTH  asynchronous field inputs, one bit per contact.
REQ-006 cond_out  output  WIDTH  synchronized, debounced input image; drives the processor IN port.
REQ-007 changed  output  1  one-cycle pulse when any cond_out bit updates.
REQ-008 rise  output  WIDTH  per-bit one-cycle pulse on a 0->1 update of cond_out; present only with INPUT_EDGE_EN.
REQ-009 fall  output  WIDTH  per-bit one-cycle pulse on a 1->0 update of cond_out; present only with INPUT_EDGE_EN.

Function
REQ-010 Each raw_in bit SHALL pass through a two-flop synchronizer (s1, s2) before any other logic.
REQ-011 Each bit SHALL own an independent counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits; no sharing between bits.
REQ-012 Per-bit states: STABLE (s2 == cond_out, counter 0) and PENDING (s2 != cond_out, counter counting).
REQ-013 STABLE -> PENDING when s2 differs from cond_out; counter increments by 1 on each edge s2 still differs.
REQ-014 PENDING -> STABLE with no output change if s2 returns to cond_out before the count completes; counter clears to 0 on that edge.
REQ-015 PENDING -> STABLE with update on the edge where s2 differs and counter == DEBOUNCE_CYCLES-1: cond_out bit <= s2, counter <= 0.
REQ-016 Latency: raw_in bit changes and holds before edge k -> cond_out bit updates at edge k+1+DEBOUNCE_CYCLES.
REQ-017 DEBOUNCE_CYCLES = 1: update one edge after s2 differs (total latency 3 edges); glitches shorter than one cycle reaching s2 still propagate.
REQ-018 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around under any input pattern.
REQ-019 changed SHALL be registered and high for exactly the cycle following an edge on which one or more bits updated (same cycle cond_out shows the new value); simultaneous updates on several bits produce a single pulse.
REQ-020 Continuous toggling of raw_in at a period shorter than DEBOUNCE_CYCLES SHALL hold cond_out unchanged indefinitely.

Reset
REQ-021 reset low: s1, s2, cond_out, counters, changed, rise and fall SHALL all go to 0 asynchronously.
REQ-022 Reset asserted mid-PENDING SHALL discard the partial count; after release, debouncing restarts from cond_out = 0.
REQ-023 After reset release, a raw_in bit held at 1 SHALL appear on cond_out at edge 2+DEBOUNCE_CYCLES counted from the first rising clk edge after release (edge 1).

Configuration
REQ-024 Macro INPUT_EDGE_EN: when defined, rise and fall ports and logic SHALL exist; when undefined, both ports SHALL be absent and no edge logic synthesized.
REQ-025 With INPUT_EDGE_EN, rise[i]/fall[i] SHALL be registered pulses aligned cycle-for-cycle with changed; rise and fall never high together for the same bit.
REQ-026 Without INPUT_EDGE_EN, cond_out and changed SHALL behave identically to the enabled build.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, INPUT_EDGE_EN defined)
REQ-027 raw_in 0x00 -> 0x01 held before edge 10 -> cond_out = 0x01 from edge 15; changed and rise[0] high one cycle; fall = 0.
REQ-028 raw_in bit 3 pulsed high for 3 cycles then low -> cond_out stays 0x00; changed never asserts.
REQ-029 raw_in 0x00 -> 0xFF in one cycle -> cond_out = 0xFF after 5 edges; exactly one changed pulse; rise = 0xFF for one cycle.
REQ-030 cond_out = 0x81, raw_in -> 0x00 -> after 5 edges cond_out = 0x00; fall = 0x81 one cycle; rise = 0.
REQ-031 raw_in = 0x10 held, reset pulsed low mid-count (after 2 counted edges) -> cond_out = 0x00 at once; after release 0x10 appears only after full 6-edge latency.
REQ-032 raw_in bit 0 toggled every 2 cycles for 100 cycles -> cond_out bit 0 constant, counter never reaches 3.
